// File: rtl/qm_pkg.sv
// rtl/qm_pkg.sv - shared types and widths for the queue-manager flag logic
package qm_pkg;

    localparam int QM_CNT_W    = 3;
    localparam int QM_SERVED_W = 16;

    typedef enum logic {
        GATE_CLEAR   = 1'b0,
        GATE_BLOCKED = 1'b1
    } gate_state_t;

endpackage

// File: rtl/gate_debounce.sv
// rtl/gate_debounce.sv - sensor synchroniser, debouncer and passage detector
//   clk     in  rising-edge clock
//   rst     in  asynchronous active-high reset
//   raw     in  raw asynchronous gate sensor (high while blocked)
//   passed  out registered 1-cycle pulse when a debounced blocked->clear passage ends
module gate_debounce
    import qm_pkg::*;
#(
    parameter int DEB_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic passed
);

    localparam int CW = $clog2(DEB_CYCLES + 1);

    logic          sync1;
    logic          sync2;
    logic          stable;
    logic [CW-1:0] deb_cnt;
    gate_state_t   state;

    // Counter runs while the synced level disagrees with the stable level; once it has
    // seen DEB_CYCLES disagreeing samples the stable level flips on the following edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1   <= 1'b0;
            sync2   <= 1'b0;
            stable  <= 1'b0;
            deb_cnt <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            if (deb_cnt == CW'(DEB_CYCLES)) begin
                stable  <= ~stable;
                deb_cnt <= '0;
            end else if (sync2 != stable) begin
                deb_cnt <= deb_cnt + CW'(1);
            end else begin
                deb_cnt <= '0;
            end
        end
    end

    // A passage is a full stable high then stable low; a sensor already high at reset
    // release therefore has to be seen stable-high first before its fall counts.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= GATE_CLEAR;
            passed <= 1'b0;
        end else begin
            passed <= 1'b0;
            case (state)
                GATE_CLEAR: begin
                    if (stable) begin
                        state <= GATE_BLOCKED;
                    end
                end
                GATE_BLOCKED: begin
                    if (!stable) begin
                        state  <= GATE_CLEAR;
                        passed <= 1'b1;
                    end
                end
                default: state <= GATE_CLEAR;
            endcase
        end
    end

endmodule

// File: rtl/queue_counter.sv
// rtl/queue_counter.sv - waiting-people counter with illegal-move error
//   clk           in  rising-edge clock
//   rst           in  asynchronous active-high reset
//   back_sensor   in  raw entry-gate sensor
//   front_sensor  in  raw exit-gate sensor
//   pcount        out people currently waiting (saturates, never wraps)
//   error         out last rejected move, held until the next event
//   enter_evt     out 1-cycle debounced entry passage pulse
//   leave_evt     out 1-cycle debounced exit passage pulse
//   served_total  out accepted leaves since reset (only with QC_SERVED_CNT_EN)
// Optional feature macro: QC_SERVED_CNT_EN
module queue_counter
    import qm_pkg::*;
#(
    parameter int CNT_W      = QM_CNT_W,
    parameter int DEB_CYCLES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             back_sensor,
    input  logic             front_sensor,
    output logic [CNT_W-1:0] pcount,
    output logic             error,
`ifdef QC_SERVED_CNT_EN
    output logic [QM_SERVED_W-1:0] served_total,
`endif
    output logic             enter_evt,
    output logic             leave_evt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    gate_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_back (
        .clk    (clk),
        .rst    (rst),
        .raw    (back_sensor),
        .passed (enter_evt)
    );

    gate_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_front (
        .clk    (clk),
        .rst    (rst),
        .raw    (front_sensor),
        .passed (leave_evt)
    );

    // Count reacts to the registered pulses, so it moves one clk after *_evt is seen.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pcount <= '0;
            error  <= 1'b0;
        end else if (enter_evt && leave_evt) begin
            // With someone waiting, the leave serves them and the entrant takes the slot.
            if (pcount == '0) begin
                pcount <= CNT_W'(1);
                error  <= 1'b1;
            end else begin
                error  <= 1'b0;
            end
        end else if (enter_evt) begin
            if (pcount == CNT_MAX) begin
                error <= 1'b1;
            end else begin
                pcount <= pcount + CNT_W'(1);
                error  <= 1'b0;
            end
        end else if (leave_evt) begin
            if (pcount == '0) begin
                error <= 1'b1;
            end else begin
                pcount <= pcount - CNT_W'(1);
                error  <= 1'b0;
            end
        end
    end

`ifdef QC_SERVED_CNT_EN
    logic leave_ok;
    assign leave_ok = leave_evt && (pcount != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            served_total <= '0;
        end else if (leave_ok && (served_total != '1)) begin
            served_total <= served_total + QM_SERVED_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_queue_counter.sv
// tb/tb_queue_counter.sv - randomized self-checking bench for queue_counter
module tb_queue_counter;

    localparam int DEB   = 4;
    localparam int CW    = 3;
    localparam int MAXC  = (1 << CW) - 1;
    localparam int SETTLE = DEB + 10;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          back_sensor = 1'b0;
    logic          front_sensor = 1'b0;
    logic [CW-1:0] pcount;
    logic          error;
    logic          enter_evt;
    logic          leave_evt;
`ifdef QC_SERVED_CNT_EN
    logic [15:0]   served_total;
`endif

    queue_counter #(.CNT_W(CW), .DEB_CYCLES(DEB)) dut (
        .clk          (clk),
        .rst          (rst),
        .back_sensor  (back_sensor),
        .front_sensor (front_sensor),
        .pcount       (pcount),
        .error        (error),
`ifdef QC_SERVED_CNT_EN
        .served_total (served_total),
`endif
        .enter_evt    (enter_evt),
        .leave_evt    (leave_evt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int ent_cnt = 0;
    int lev_cnt = 0;

    // reference model state: people waiting, error level, accepted leaves
    int m_cnt = 0;
    int m_err = 0;
    int m_srv = 0;

    always @(negedge clk) begin
        if (enter_evt) ent_cnt++;
        if (leave_evt) lev_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic model(input bit e, input bit l);
        if (l && m_cnt > 0 && m_srv < 65535) m_srv++;
        if (e && l) begin
            if (m_cnt == 0) begin m_cnt = 1; m_err = 1; end
            else m_err = 0;
        end else if (e) begin
            if (m_cnt == MAXC) m_err = 1;
            else begin m_cnt++; m_err = 0; end
        end else if (l) begin
            if (m_cnt == 0) m_err = 1;
            else begin m_cnt--; m_err = 0; end
        end
    endtask

    task automatic check_state(input string tag);
        check({tag, ".pcount"}, 32'(pcount), 32'(m_cnt));
        check({tag, ".error"}, 32'(error), 32'(m_err));
`ifdef QC_SERVED_CNT_EN
        check({tag, ".served"}, 32'(served_total), 32'(m_srv));
`endif
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        back_sensor = 1'b0;
        front_sensor = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        m_cnt = 0; m_err = 0; m_srv = 0;
        repeat (3) @(posedge clk);
        #1;
    endtask

    // Drive both sensors for 'width' samples, let everything settle, then compare.
    // Pulses of at least DEB samples are passages, shorter ones are glitches.
    task automatic op(input string tag, input bit b, input bit f, input int width);
        int e0, l0;
        bit clean;
        e0 = ent_cnt;
        l0 = lev_cnt;
        clean = (width >= DEB);
        @(posedge clk); #1;
        back_sensor = b;
        front_sensor = f;
        repeat (width) @(posedge clk);
        #1;
        back_sensor = 1'b0;
        front_sensor = 1'b0;
        repeat (SETTLE) @(posedge clk);
        #1;
        model(clean && b, clean && f);
        check({tag, ".enter_evts"}, 32'(ent_cnt - e0), 32'(clean && b));
        check({tag, ".leave_evts"}, 32'(lev_cnt - l0), 32'(clean && f));
        check_state(tag);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1);
    end

    initial begin
        int k;
        int e0;
        // reset values
        repeat (2) @(posedge clk);
        #1;
        check("reset.pcount", 32'(pcount), 0);
        check("reset.error", 32'(error), 0);
        check("reset.evts", 32'({enter_evt, leave_evt}), 0);
        do_reset();
        check_state("post_reset");

        // 1: clean 10-clk entry pulse, with exact latency
        e0 = ent_cnt;
        @(posedge clk); #1 back_sensor = 1'b1;
        repeat (10) @(posedge clk);
        #1 back_sensor = 1'b0;
        k = 0;
        for (int i = 1; i <= 30; i++) begin
            @(posedge clk); #1;
            if (enter_evt) begin k = i; break; end
        end
        // edge index DEB+3 counted from the first sampling edge (index 0)
        check("t1.latency", 32'(k), 32'(DEB + 4));
        check("t1.pcount_at_evt", 32'(pcount), 0);
        @(posedge clk); #1;
        check("t1.pcount_after", 32'(pcount), 1);
        repeat (SETTLE) @(posedge clk);
        #1;
        model(1, 0);
        check("t1.enter_evts", 32'(ent_cnt - e0), 1);
        check_state("t1");

        // 2: 2-clk glitch
        op("t2_glitch", 1, 0, 2);

        // 3: leave on empty, then a clean enter
        do_reset();
        op("t3_leave_empty", 0, 1, 10);
        op("t3_enter", 1, 0, 10);

        // 4: fill past MAX, then one leave
        do_reset();
        for (int i = 0; i < 8; i++) op("t4_fill", 1, 0, 8);
        op("t4_leave", 0, 1, 8);

        // 5: simultaneous passages at 3 and at 0
        do_reset();
        for (int i = 0; i < 3; i++) op("t5_prep", 1, 0, 8);
        op("t5_both_at3", 1, 1, 9);
        do_reset();
        op("t5_both_at0", 1, 1, 9);

        // 6: reset mid-debounce with the entry sensor high
        op("t6_prep", 1, 0, 8);
        op("t6_prep", 1, 0, 8);
        e0 = ent_cnt;
        @(posedge clk); #1 back_sensor = 1'b1;
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("t6.pcount_in_rst", 32'(pcount), 0);
        check("t6.error_in_rst", 32'(error), 0);
        check("t6.evts_in_rst", 32'({enter_evt, leave_evt}), 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        m_cnt = 0; m_err = 0; m_srv = 0;
        @(posedge clk); #1 back_sensor = 1'b0;
        repeat (SETTLE) @(posedge clk);
        #1;
        check("t6.enter_evts", 32'(ent_cnt - e0), 0);
        check_state("t6");
        op("t6_fill", 1, 0, 8);
        op("t6_fill", 1, 0, 8);
        op("t6_fill", 1, 0, 8);
        op("t6_serve", 0, 1, 8);
        op("t6_serve", 0, 1, 8);
        op("t6_serve", 1, 1, 8);

        // randomized operations against the model
        do_reset();
        for (int i = 0; i < 60; i++) begin
            int kind;
            kind = int'($urandom_range(0, 9));
            case (kind)
                0, 1, 2, 3: op("rnd_enter", 1, 0, int'($urandom_range(DEB + 2, 14)));
                4, 5:       op("rnd_leave", 0, 1, int'($urandom_range(DEB + 2, 14)));
                6:          op("rnd_both", 1, 1, int'($urandom_range(DEB + 2, 14)));
                7:          op("rnd_gl_back", 1, 0, int'($urandom_range(1, DEB - 1)));
                8:          op("rnd_gl_front", 0, 1, int'($urandom_range(1, DEB - 1)));
                default:    op("rnd_gl_both", 1, 1, int'($urandom_range(1, DEB - 1)));
            endcase
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
